// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM states and access legality check for the LSU
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;
    typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} lsu_state_t;
    function automatic logic is_legal(input logic wr, input logic [2:0] funct3, input logic [1:0] a);
        return (funct3 == F3_B) || (funct3 == F3_BU && !wr) ||
               (funct3 == F3_H && !a[0]) || (funct3 == F3_HU && !wr && !a[0]) ||
               (funct3 == F3_W && a == 2'b00);
    endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: extracts/extends load lanes and merges store lanes into a word
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  a,
    input  logic [31:0] word_in,
    input  logic [31:0] wdata,
    output logic [31:0] load_ext,
    output logic [31:0] store_merge
);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] mask;
    logic [31:0] data;
    assign b = word_in[{a, 3'b000} +: 8];
    assign h = a[1] ? word_in[31:16] : word_in[15:0];
    assign load_ext = funct3 == F3_B  ? {{24{b[7]}}, b} :
                      funct3 == F3_BU ? {24'h0, b} :
                      funct3 == F3_H  ? {{16{h[15]}}, h} :
                      funct3 == F3_HU ? {16'h0, h} : word_in;
    assign mask = funct3 == F3_B ? 32'hFF << {a, 3'b000} :
                  funct3 == F3_H ? 32'hFFFF << {a[1], 4'b0000} : 32'hFFFF_FFFF;
    assign data = funct3 == F3_B ? {4{wdata[7:0]}} :
                  funct3 == F3_H ? {2{wdata[15:0]}} : wdata;
    assign store_merge = (word_in & ~mask) | (data & mask);
endmodule

// File: rtl/lsu_dmem_initiator.sv
// lsu_dmem_initiator: RV32I load/store unit driving a word-wide data memory port
module lsu_dmem_initiator
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              fault,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd
);
    lsu_state_t        state, nxt;
    logic [ADDR_W-1:0] a_r;
    logic [2:0]        f3_r;
    logic [31:0]       wd_r, buf_r, load_ext;
    logic              fault_r;
    logic              unused_hi;
    assign unused_hi = ^addr[31:ADDR_W];
    assign busy     = state != IDLE;
    assign done     = state == RESP;
    assign fault    = done & fault_r;
    assign mem_we   = state == WR;
    assign mem_addr = {a_r[ADDR_W-1:2], 2'b00};
    lsu_lane_align u_align (
        .funct3      (f3_r),
        .a           (a_r[1:0]),
        .word_in     (state == RD ? mem_rd : buf_r),
        .wdata       (wd_r),
        .load_ext    (load_ext),
        .store_merge (mem_wd)
    );
    always_comb begin
        nxt = state == IDLE ? (!req ? IDLE :
                               !is_legal(wr, funct3, addr[1:0]) ? RESP :
                               !wr ? RD :
                               funct3 == F3_W ? WR : RMW_RD) :
              (state == RD || state == WR) ? RESP :
              state == RMW_RD ? WR : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_r     <= '0;
            f3_r    <= '0;
            wd_r    <= '0;
            buf_r   <= '0;
            rdata   <= '0;
            fault_r <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && req) begin
                a_r     <= addr[ADDR_W-1:0];
                f3_r    <= funct3;
                wd_r    <= wdata;
                fault_r <= !is_legal(wr, funct3, addr[1:0]);
            end
            if (state == RD) rdata <= load_ext;
            if (state == RMW_RD) buf_r <= mem_rd;
        end
    end
endmodule

// File: doc/lsu_dmem_initiator.md
Name: lsu_dmem_initiator

Overview:
- Load/store unit that is the CPU-side initiator of the data-memory bus.
- Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-wide accesses on the DM port: addr, wd, we, and a combinationally read rd.
- The DM has only a word write enable, so sub-word stores use a read-modify-write sequence.
- Sits between the execute stage and the memory block; reports done/fault back to the core controller.

Parameters:
- ADDR_W, 16, width of mem_addr (byte address into DM).
- DATA_W, 32, data word width; fixed at 32, not generic.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  request strobe; sampled only in IDLE.
- wr  in  1  1 = store, 0 = load; sampled with req.
- funct3  in  3  RV32I size/sign code; sampled with req.
- addr  in  32  byte address; bits [31:ADDR_W] ignored.
- wdata  in  32  store data, right-aligned; sampled with req.
- rdata  out  32  load result, extended; valid while done=1 and held until next load completes.
- done  out  1  one-cycle completion pulse.
- fault  out  1  valid with done; 1 = misaligned or illegal funct3, no memory access made.
- busy  out  1  high in every state except IDLE.
- mem_addr  out  ADDR_W  word-aligned byte address; bits [1:0] are always 0.
- mem_wd  out  32  write data to DM.
- mem_we  out  1  DM write enable; the write commits on the rising edge ending a cycle with mem_we=1.
- mem_rd  in  32  DM read data; combinational from mem_addr.

Behaviour:
- Reset values: rdata=0, done=0, fault=0, busy=0, mem_we=0, mem_addr=0, mem_wd=0, state=IDLE.
- States: IDLE, RD, RMW_RD, WR, RESP.
- In IDLE with req=1, the block latches addr, funct3, wr and wdata.
- Fault detection in IDLE:
  - funct3 in {3,6,7}, or store with funct3 not in {0,1,2} → fault.
  - Halfword with addr[0]=1 → fault.
  - Word with addr[1:0]≠0 → fault.
  - On fault, go to RESP with fault=1.
- Transitions without fault:
  - Load → RD.
  - SW → WR.
  - SB/SH → RMW_RD.
- RD:
  - Drive mem_addr={addr[ADDR_W-1:2],2'b00}.
  - Select the byte lane from addr[1:0] and the halfword lane from addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Register the result into rdata; go to RESP.
- RMW_RD: drive mem_addr; capture mem_rd into the merge buffer; go to WR.
- WR:
  - mem_we=1 for exactly this cycle.
  - mem_wd = merged word: wdata[7:0] or wdata[15:0] replaces the addressed lane, other lanes come from the buffer. SW uses wdata directly.
  - Go to RESP.
- RESP: done=1 for exactly this cycle; fault as determined; go to IDLE.
- mem_we is a decode of state==WR only; it is never high in any other state.
- Latency, with req sampled at edge N:
  - Load: done in cycle N+2.
  - SW: write commits at the end of N+1; done in N+2.
  - SB/SH: done in N+3.
  - Fault: done in N+1.
- req while busy=1 is ignored (no queuing); the requester must wait for done.
- req in the RESP cycle is also ignored; a new request is accepted only in IDLE.
- rdata is updated only by a successful load; stores and faults leave it unchanged.
- Reset mid-operation: the next edge returns to IDLE with all outputs at reset values. An in-flight RMW is abandoned before its write; no partial write occurs unless the state was already WR at that edge.
- Address wrap: addr bits above ADDR_W are silently truncated.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
  - State enum lsu_state_t {IDLE, RD, RMW_RD, WR, RESP}.
  - Function is_legal(wr, funct3, addr[1:0]).
- One combinational sub-module, lsu_lane_align, takes (funct3, addr[1:0], word_in, wdata) and produces (load_ext, store_merge).
- The top level keeps the FSM and the registers.

Test Plan:
- Word round trip: SW addr=0x0010 wdata=0xDEADBEEF, then LW 0x0010 → one mem_we pulse with mem_wd=0xDEADBEEF; LW done at N+2 with rdata=0xDEADBEEF, fault=0.
- Sub-word store: preload word 0x11223344 at 0x0020, SB addr=0x0021 wdata=0xAB → mem_we only in cycle N+2, mem_wd=0x1122AB44; done at N+3; LW returns 0x1122AB44.
- Extension: word 0x80FF7F01 at 0x0030.
  - LB 0x0032 → 0xFFFFFFFF; LBU 0x0032 → 0x000000FF.
  - LH 0x0032 → 0xFFFF80FF; LHU 0x0030 → 0x00007F01.
- Faults: LW 0x0031, SH 0x0033, funct3=3 → done at N+1 with fault=1, mem_we never asserted, rdata unchanged.
- Busy/ignore: assert req continuously during an SH to 0x0040; a second req with different addr while busy → only one access sequence occurs; the next request starts only from IDLE.
- Reset mid-RMW: SH to 0x0044, assert rst in the RMW_RD cycle → no mem_we pulse, memory word unchanged; after reset, busy=0, done=0, rdata=0.
